// File: rtl/synth_bus_arbiter.sv
// Round-robin arbiter and setup/strobe/release sequencer for the synth controller data bus.
// Optional SYNTH_BUS_LOCK_EN adds req_lock for back-to-back bursts from one requester.
module synth_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 7,
  parameter int SEL_LINES   = 5,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                          CLOCK_25,
  input  logic                          reset_reg_N,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*SEL_LINES-1:0]  req_sel,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
`ifdef SYNTH_BUS_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [ADDR_W-1:0]             adr,
  output logic [SEL_LINES-1:0]          sel_out,
  output logic                          write,
  output logic                          read,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_oe,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          busy
);

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int CW = clogb2(WAIT_CYCLES + 1);
  localparam int IW = (NUM_REQ > 1) ? clogb2(NUM_REQ) : 1;

  typedef struct packed {
    logic                 write;
    logic [ADDR_W-1:0]    addr;
    logic [SEL_LINES-1:0] sel;
    logic [DATA_W-1:0]    wdata;
    logic                 err;
    logic [IW-1:0]        id;
  } txn_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t                   state, state_nx;
  txn_t [NUM_REQ-1:0]       lane;
  txn_t                     cur, pick;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            ptr, win;
  logic [DATA_W-1:0]        rdata_q;
  logic                     any, take, relock, act, last_strobe;

  // Per-requester view of the packed request buses, with select legality precomputed.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane[gi] = '{write: req_write[gi],
                        addr:  req_addr[gi*ADDR_W +: ADDR_W],
                        sel:   req_sel[gi*SEL_LINES +: SEL_LINES],
                        wdata: req_wdata[gi*DATA_W +: DATA_W],
                        err:   !$onehot(req_sel[gi*SEL_LINES +: SEL_LINES]),
                        id:    IW'(gi)};
  end

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    any = 1'b0;
    win = '0;
    j   = 0;
    jj  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (req_valid[jj]) begin
        any = 1'b1;
        win = jj;
      end
    end
  end

`ifdef SYNTH_BUS_LOCK_EN
  assign relock = req_lock[cur.id] & req_valid[cur.id];
`else
  assign relock = 1'b0;
`endif

  assign last_strobe = (state == STROBE) && (cnt == CW'(1));
  assign pick        = (state == IDLE) ? lane[win] : lane[cur.id];

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    take      = 1'b0;
    case (state)
      IDLE:    if (any) begin
                 req_ready[win] = 1'b1;
                 take           = 1'b1;
                 state_nx       = SETUP;
               end
      SETUP:   state_nx = STROBE;
      STROBE:  if (last_strobe) state_nx = RELEASE;
      RELEASE: if (relock) begin
                 req_ready[cur.id] = 1'b1;
                 take              = 1'b1;
                 state_nx          = SETUP;
               end else begin
                 state_nx = IDLE;
               end
      default: state_nx = IDLE;
    endcase
    if (!reset_reg_N) begin
      req_ready = '0;
      take      = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= state_nx;
  end

  always_ff @(posedge CLOCK_25) begin
    if (!reset_reg_N) begin
      cur     <= '0;
      cnt     <= '0;
      ptr     <= '0;
      rdata_q <= '0;
    end else begin
      if (take) cur <= pick;
      if (state == SETUP)       cnt <= CW'(WAIT_CYCLES);
      else if (state == STROBE) cnt <= cnt - 1'b1;
      // Writes and illegal selects report zero read data.
      if (last_strobe) rdata_q <= (!cur.write && !cur.err) ? data_in : '0;
      if (state == RELEASE && !relock)
        ptr <= (cur.id == IW'(NUM_REQ - 1)) ? '0 : cur.id + 1'b1;
    end
  end

  assign act       = (state == SETUP || state == STROBE) && !cur.err;
  assign adr       = cur.addr;
  assign sel_out   = act ? cur.sel : '0;
  assign data_oe   = act & cur.write;
  assign data_out  = data_oe ? cur.wdata : '0;
  assign write     = (state == STROBE) & cur.write & !cur.err;
  assign read      = (state == STROBE) & !cur.write & !cur.err;
  assign rsp_valid = (state == RELEASE) ? (NUM_REQ'(1) << cur.id) : '0;
  assign rsp_err   = (state == RELEASE) & cur.err;
  assign rsp_rdata = rdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_synth_bus_arbiter.sv
// Directed bench for synth_bus_arbiter: handshake timing, round-robin order, illegal select, reset abort.
module tb_synth_bus_arbiter;
  localparam int NR = 2, AW = 7, SW = 5, DW = 8;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*SW-1:0]  req_sel;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_lock;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     adr;
  logic [SW-1:0]     sel_out;
  logic              write, read, data_oe, busy;
  logic [DW-1:0]     data_out, data_in;

  int checks = 0;
  int failures = 0;

  synth_bus_arbiter dut (
    .CLOCK_25    (clk),
    .reset_reg_N (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_sel     (req_sel),
    .req_wdata   (req_wdata),
`ifdef SYNTH_BUS_LOCK_EN
    .req_lock    (req_lock),
`endif
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .adr         (adr),
    .sel_out     (sel_out),
    .write       (write),
    .read        (read),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .data_in     (data_in),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic setreq(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [SW-1:0] s, input logic [DW-1:0] d);
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_sel[i*SW +: SW]  = s;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [NR-1:0] eg;
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
    req_sel = '0; req_wdata = '0; req_lock = '0; data_in = '0;
    adv(); adv();
    smp();
    chk("rst_busy", busy, 0);       chk("rst_adr", adr, 0);
    chk("rst_sel", sel_out, 0);     chk("rst_wr", write, 0);
    chk("rst_rd", read, 0);         chk("rst_oe", data_oe, 0);
    chk("rst_rsp", rsp_valid, 0);   chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", req_ready, 0); chk("rst_dout", data_out, 0);
    adv(); rst_n = 1'b1;

    // Single CPU write
    adv(); req_valid = 2'b01; setreq(0, 1'b1, 7'h02, 5'b10000, 8'hA5);
    smp(); chk("w_c0_ready", req_ready, 2'b01); chk("w_c0_busy", busy, 0);
    adv(); req_valid = '0;
    smp(); chk("w_c1_adr", adr, 7'h02); chk("w_c1_sel", sel_out, 5'b10000);
           chk("w_c1_oe", data_oe, 1); chk("w_c1_dout", data_out, 8'hA5);
           chk("w_c1_wr", write, 0);   chk("w_c1_busy", busy, 1);
    adv(); smp(); chk("w_c2_wr", write, 1); chk("w_c2_oe", data_oe, 1); chk("w_c2_rd", read, 0);
    adv(); smp(); chk("w_c3_wr", write, 1); chk("w_c3_sel", sel_out, 5'b10000);
    adv(); smp(); chk("w_c4_rsp", rsp_valid, 2'b01); chk("w_c4_err", rsp_err, 0);
           chk("w_c4_wr", write, 0); chk("w_c4_sel", sel_out, 0);
           chk("w_c4_oe", data_oe, 0); chk("w_c4_adr", adr, 7'h02); chk("w_c4_rdata", rsp_rdata, 0);
    adv(); smp(); chk("w_c5_rsp", rsp_valid, 0); chk("w_c5_busy", busy, 0);

    // Single MIDI read
    adv(); req_valid = 2'b10; setreq(1, 1'b0, 7'h11, 5'b01000, 8'h00); data_in = 8'h3C;
    smp(); chk("r_c0_ready", req_ready, 2'b10);
    adv(); req_valid = '0;
    smp(); chk("r_c1_adr", adr, 7'h11); chk("r_c1_oe", data_oe, 0); chk("r_c1_rd", read, 0);
    adv(); smp(); chk("r_c2_rd", read, 1); chk("r_c2_wr", write, 0);
    adv(); smp(); chk("r_c3_rd", read, 1);
    adv(); smp(); chk("r_c4_rsp", rsp_valid, 2'b10); chk("r_c4_rdata", rsp_rdata, 8'h3C);
           chk("r_c4_err", rsp_err, 0);
    adv(); data_in = 8'h00;
    smp(); chk("r_c5_hold", rsp_rdata, 8'h3C);

    // Invalid select (read) on requester 0
    adv(); req_valid = 2'b01; setreq(0, 1'b0, 7'h09, 5'b00110, 8'h00); data_in = 8'h5A;
    smp(); chk("e_c0_ready", req_ready, 2'b01);
    adv(); req_valid = '0;
    smp(); chk("e_c1_sel", sel_out, 0); chk("e_c1_busy", busy, 1);
    adv(); smp(); chk("e_c2_rd", read, 0); chk("e_c2_wr", write, 0); chk("e_c2_sel", sel_out, 0);
    adv(); smp(); chk("e_c3_rd", read, 0);
    adv(); smp(); chk("e_c4_rsp", rsp_valid, 2'b01); chk("e_c4_err", rsp_err, 1);
           chk("e_c4_rdata", rsp_rdata, 0);

    // Reset during STROBE of a requester-1 read
    adv(); req_valid = 2'b10; setreq(1, 1'b0, 7'h44, 5'b00010, 8'h00); data_in = 8'h99;
    smp(); chk("x_c0_ready", req_ready, 2'b10);
    adv(); req_valid = '0;
    adv(); rst_n = 1'b0;
    smp(); chk("x_c2_rd", read, 1);
    adv(); smp(); chk("x_c3_busy", busy, 0); chk("x_c3_rd", read, 0);
           chk("x_c3_adr", adr, 0); chk("x_c3_sel", sel_out, 0); chk("x_c3_rsp", rsp_valid, 0);
    adv(); smp(); chk("x_c4_rsp", rsp_valid, 0);
    adv(); rst_n = 1'b1;

    // Both requesters continuously: grants alternate starting at 0
    adv(); req_valid = 2'b11;
    setreq(0, 1'b1, 7'h05, 5'b00001, 8'h11);
    setreq(1, 1'b1, 7'h06, 5'b00010, 8'h22);
    for (int t = 0; t < 4; t++) begin
      eg = (t % 2 == 0) ? 2'b01 : 2'b10;
      smp(); chk("rr_grant", req_ready, eg);
      for (int c = 1; c <= 4; c++) begin
        adv();
        if (c == 1 && t == 3) req_valid = '0;
        smp();
        if (c == 1) chk("rr_noready", req_ready, 0);
        if (c == 2) chk("rr_adr", adr, (t % 2 == 0) ? 7'h05 : 7'h06);
        if (c == 4) chk("rr_rsp", rsp_valid, eg);
      end
      adv();
    end
    smp(); chk("rr_idle", busy, 0); chk("rr_idle_ready", req_ready, 0);

`ifdef SYNTH_BUS_LOCK_EN
    // Locked burst from requester 1 while requester 0 waits
    adv(); req_lock = 2'b10; req_valid = 2'b10; setreq(1, 1'b1, 7'h20, 5'b00100, 8'h31);
    smp(); chk("l_c0_ready", req_ready, 2'b10);
    adv(); req_valid = 2'b11; setreq(0, 1'b1, 7'h30, 5'b00001, 8'h40);
           setreq(1, 1'b1, 7'h21, 5'b00100, 8'h32);
    smp(); chk("l_c1_ready", req_ready, 0);
    adv(); smp(); chk("l_c2_adr", adr, 7'h20); chk("l_c2_wr", write, 1);
    adv(); adv(); smp(); chk("l_c4_ready", req_ready, 2'b10); chk("l_c4_rsp", rsp_valid, 2'b10);
    adv(); setreq(1, 1'b1, 7'h22, 5'b00100, 8'h33);
    smp(); chk("l_c5_adr", adr, 7'h21); chk("l_c5_busy", busy, 1);
    adv(); smp(); chk("l_c6_wr", write, 1);
    adv(); adv(); smp(); chk("l_c8_ready", req_ready, 2'b10); chk("l_c8_rsp", rsp_valid, 2'b10);
    adv(); req_lock = '0; req_valid = 2'b01;
    smp(); chk("l_c9_adr", adr, 7'h22);
    adv(); adv(); adv(); smp(); chk("l_c12_rsp", rsp_valid, 2'b10); chk("l_c12_ready", req_ready, 0);
    adv(); smp(); chk("l_c13_ready", req_ready, 2'b01);
    adv(); req_valid = '0;
    repeat (5) adv();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
